// File: rtl/fsm_spir_adc_nch.sv
// -----------------------------------------------------------------------------
// fsm_spir_adc_nch
//
// SPI-read controller for multi-channel ADC readout. Each start request reads
// NCH frames back to back. Every frame is FRAME_BITS slow_clk_i ticks long.
// The first SKIP_BITS bits are discarded, the next DATA_W bits are shifted in
// MSB first, and any remaining bits are clocked but dropped. After each frame
// the captured word is presented on data_o with a one-cycle valid_o strobe.
// GAP_TICKS idle ticks separate consecutive frames. After the last channel,
// hab_o pulses once.
//
// Optional feature: macro SPIR_CONT_EN adds input cont_i. When cont_i is high
// in DONE, a new scan starts immediately. IDLE is skipped and eor_o stays low.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-low reset
//   strr_i      start request (level, sampled in IDLE only)
//   slow_clk_i  one-clk-wide SPI sample tick
//   miso_i      serial data from the ADC
//   cont_i      continuous-scan enable (SPIR_CONT_EN builds only)
//   data_o      last captured word
//   ch_o        channel index of data_o / current frame
//   valid_o     one-cycle strobe when data_o/ch_o are updated
//   eor_o       end-of-read: high in IDLE, low while reading
//   hab_o       one-cycle done pulse after the last channel
//   cnt_o       bit count within the current frame
// -----------------------------------------------------------------------------
module fsm_spir_adc_nch #(
   parameter int FRAME_BITS = 32,
   parameter int SKIP_BITS  = 14,
   parameter int DATA_W     = 18,
   parameter int NCH        = 4,
   parameter int GAP_TICKS  = 2,
   localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int CNT_W     = $clog2(FRAME_BITS + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              strr_i,
   input  logic              slow_clk_i,
   input  logic              miso_i,
`ifdef SPIR_CONT_EN
   input  logic              cont_i,
`endif
   output logic [DATA_W-1:0] data_o,
   output logic [CH_W-1:0]   ch_o,
   output logic              valid_o,
   output logic              eor_o,
   output logic              hab_o,
   output logic [CNT_W-1:0]  cnt_o
);

   localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   localparam logic [CNT_W-1:0] SKIP_C  = CNT_W'(SKIP_BITS);
   localparam logic [CNT_W-1:0] DEND_C  = CNT_W'(SKIP_BITS + DATA_W);
   localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_BITS);
   localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NCH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_CHK,
      S_LATCH,
      S_GAP,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [DATA_W-1:0]  data_q;
   logic [DATA_W-1:0]  shift_q;
   logic [CH_W-1:0]    ch_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [GAP_W-1:0]   gap_q;
   logic               valid_q;
   logic               eor_q;
   logic               hab_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         shift_q <= '0;
         ch_q    <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         valid_q <= 1'b0;
         eor_q   <= 1'b1;
         hab_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         hab_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               eor_q <= 1'b1;
               if (strr_i) begin
                  ch_q    <= '0;
                  cnt_q   <= '0;
                  shift_q <= '0;
                  eor_q   <= 1'b0;
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (slow_clk_i) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  // Window test uses the pre-increment count: bit index within frame.
                  if (cnt_q >= SKIP_C && cnt_q < DEND_C) begin
                     shift_q <= {shift_q[DATA_W-2:0], miso_i};
                  end
                  state_q <= S_CHK;
               end
            end

            S_CHK: begin
               state_q <= (cnt_q == FRAME_C) ? S_LATCH : S_WAIT;
            end

            S_LATCH: begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
               if (ch_q == CH_LAST) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q   <= '0;
                  shift_q <= '0;
                  gap_q   <= '0;
                  state_q <= S_GAP;
               end
            end

            S_GAP: begin
               if (GAP_TICKS == 0) begin
                  ch_q    <= ch_q + CH_W'(1);
                  state_q <= S_WAIT;
               end else if (slow_clk_i) begin
                  if (gap_q == GAP_LAST) begin
                     ch_q    <= ch_q + CH_W'(1);
                     state_q <= S_WAIT;
                  end else begin
                     gap_q <= gap_q + GAP_W'(1);
                  end
               end
            end

            S_DONE: begin
               hab_q <= 1'b1;
               cnt_q <= '0;
`ifdef SPIR_CONT_EN
               if (cont_i) begin
                  ch_q    <= '0;
                  shift_q <= '0;
                  state_q <= S_WAIT;
               end else begin
                  eor_q   <= 1'b1;
                  state_q <= S_IDLE;
               end
`else
               eor_q   <= 1'b1;
               state_q <= S_IDLE;
`endif
            end

            default: begin
               eor_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign data_o  = data_q;
   assign ch_o    = ch_q;
   assign valid_o = valid_q;
   assign eor_o   = eor_q;
   assign hab_o   = hab_q;
   assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_fsm_spir_adc_nch.sv
// -----------------------------------------------------------------------------
// tb_fsm_spir_adc_nch
//
// Bench for fsm_spir_adc_nch. It uses two instances:
//   dut  : default parameters (4 channels, 32-bit frames, 14 skip bits, gap 2)
//   dut2 : NCH=1, GAP_TICKS=0, FRAME_BITS=24, SKIP_BITS=6
// Builds with SPIR_CONT_EN defined also exercise continuous scanning on dut.
// -----------------------------------------------------------------------------
module tb_fsm_spir_adc_nch;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic strr = 1'b0, slow = 1'b0, miso = 1'b0;
   logic strr2 = 1'b0, slow2 = 1'b0, miso2 = 1'b0;
`ifdef SPIR_CONT_EN
   logic cont = 1'b0;
`endif

   logic [17:0] data, data2;
   logic [1:0]  ch;
   logic [0:0]  ch2;
   logic        valid, eor, hab, valid2, eor2, hab2;
   logic [5:0]  cnt;
   logic [4:0]  cnt2;

   always #5 clk = ~clk;

   fsm_spir_adc_nch dut (
      .clk_i(clk), .rst_i(rst), .strr_i(strr), .slow_clk_i(slow), .miso_i(miso),
`ifdef SPIR_CONT_EN
      .cont_i(cont),
`endif
      .data_o(data), .ch_o(ch), .valid_o(valid), .eor_o(eor), .hab_o(hab), .cnt_o(cnt)
   );

   fsm_spir_adc_nch #(
      .FRAME_BITS(24), .SKIP_BITS(6), .DATA_W(18), .NCH(1), .GAP_TICKS(0)
   ) dut2 (
      .clk_i(clk), .rst_i(rst), .strr_i(strr2), .slow_clk_i(slow2), .miso_i(miso2),
`ifdef SPIR_CONT_EN
      .cont_i(1'b0),
`endif
      .data_o(data2), .ch_o(ch2), .valid_o(valid2), .eor_o(eor2), .hab_o(hab2), .cnt_o(cnt2)
   );

   // Output monitor: logs strobes and pulses with their cycle numbers.
   int          cyc = 0;
   logic [17:0] vdata[$];
   int          vch[$];
   int          vcyc[$];
   int          hab_n = 0, hab_cyc = 0, eor_hi = 0;
   int          v2_n = 0, v2_cyc = 0, h2_n = 0, h2_cyc = 0, cnt2_max = 0;
   logic [17:0] v2_data = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (valid) begin
         vdata.push_back(data);
         vch.push_back(int'(ch));
         vcyc.push_back(cyc);
      end
      if (hab) begin
         hab_n   = hab_n + 1;
         hab_cyc = cyc;
      end
      if (eor) eor_hi = eor_hi + 1;
      if (valid2) begin
         v2_n    = v2_n + 1;
         v2_data = data2;
         v2_cyc  = cyc;
      end
      if (hab2) begin
         h2_n   = h2_n + 1;
         h2_cyc = cyc;
      end
      if (int'(cnt2) > cnt2_max) cnt2_max = int'(cnt2);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One SPI tick: six clk cycles per tick, satisfying the spacing rule.
   task automatic tick(input bit sel2, input logic b);
      @(posedge clk); #1;
      if (sel2) begin miso2 = b; slow2 = 1'b1; end
      else      begin miso  = b; slow  = 1'b1; end
      @(posedge clk); #1;
      slow = 1'b0; slow2 = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic pulse_strr();
      @(posedge clk); #1; strr = 1'b1;
      @(posedge clk); #1; strr = 1'b0;
   endtask

   // Sends nbits of a default-parameter frame: skip bits = skipb, then w MSB first.
   task automatic frame_part(input logic skipb, input logic [17:0] w,
                             input int first, input int last);
      for (int i = first; i < last; i++) begin
         if (i < 14) tick(1'b0, skipb);
         else        tick(1'b0, w[31-i]);
      end
   endtask

   // Gap ticks drive the skip level so that a miscounted gap corrupts the data.
   task automatic gap(input logic skipb);
      tick(1'b0, skipb);
      tick(1'b0, skipb);
   endtask

   // Four-channel scan. If repulse is set, strr is pulsed in the middle of channel 1.
   task automatic scan(input logic skipb, input logic [17:0] w, input bit repulse);
      pulse_strr();
      @(negedge clk);
      chk("eor_low_in_scan", {31'd0, eor}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         if (repulse && c == 1) begin
            frame_part(skipb, w, 0, 10);
            pulse_strr();
            frame_part(skipb, w, 10, 32);
         end else begin
            frame_part(skipb, w, 0, 32);
         end
         if (c < 3) gap(skipb);
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_scan(input string tag, input int vbase, input int hbase,
                             input logic [17:0] expw);
      chk({tag, "_valid_count"}, vdata.size() - vbase, 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (vbase + k < vdata.size()) begin
            chk({tag, "_data"}, {14'd0, vdata[vbase+k]}, {14'd0, expw});
            chk({tag, "_ch"}, vch[vbase+k], k);
         end
      end
      chk({tag, "_hab_count"}, hab_n - hbase, 32'd1);
      if (vdata.size() > 0)
         chk({tag, "_hab_after_valid"}, hab_cyc, vcyc[vdata.size()-1] + 1);
      chk({tag, "_eor_end"}, {31'd0, eor}, 32'd1);
      chk({tag, "_cnt_end"}, {26'd0, cnt}, 32'd0);
   endtask

   typedef struct {
      string       tag;
      logic        skipb;
      logic [17:0] word;
      logic [17:0] expw;
   } vec_t;

   vec_t vecs[4];
   int   vb, hb;

   initial begin
      vecs[0] = '{"scan_a5c3",   1'b0, 18'h2A5C3, 18'h2A5C3};
      vecs[1] = '{"scan_skip1",  1'b1, 18'h00001, 18'h00001};
      vecs[2] = '{"scan_ones",   1'b1, 18'h3FFFF, 18'h3FFFF};
      vecs[3] = '{"scan_msb",    1'b0, 18'h20000, 18'h20000};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data",  {14'd0, data}, 32'd0);
      chk("rst_ch",    {30'd0, ch},   32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_eor",   {31'd0, eor},  32'd1);
      chk("rst_hab",   {31'd0, hab},  32'd0);
      chk("rst_cnt",   {26'd0, cnt},  32'd0);
      @(posedge clk); #1; rst = 1'b1;

      // Table-driven full scans
      for (int v = 0; v < 4; v++) begin
         vb = vdata.size(); hb = hab_n;
         scan(vecs[v].skipb, vecs[v].word, 1'b0);
         check_scan(vecs[v].tag, vb, hb, vecs[v].expw);
      end

      // Start request during channel 1 is ignored
      vb = vdata.size(); hb = hab_n;
      scan(1'b0, 18'h15A3C, 1'b1);
      check_scan("repulse", vb, hb, 18'h15A3C);

      // Reset at bit 20 of channel 2 aborts the scan
      vb = vdata.size(); hb = hab_n;
      pulse_strr();
      for (int c = 0; c < 2; c++) begin
         frame_part(1'b0, 18'h2A5C3, 0, 32);
         gap(1'b0);
      end
      frame_part(1'b0, 18'h2A5C3, 0, 20);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("abort_data",  {14'd0, data}, 32'd0);
      chk("abort_ch",    {30'd0, ch},   32'd0);
      chk("abort_valid", {31'd0, valid}, 32'd0);
      chk("abort_eor",   {31'd0, eor},  32'd1);
      chk("abort_hab",   {31'd0, hab},  32'd0);
      chk("abort_cnt",   {26'd0, cnt},  32'd0);
      repeat (3) @(posedge clk);
      #1; rst = 1'b1;
      chk("abort_valid_count", vdata.size() - vb, 32'd2);
      chk("abort_hab_count", hab_n - hb, 32'd0);
      vb = vdata.size(); hb = hab_n;
      scan(1'b0, 18'h2A5C3, 1'b0);
      check_scan("post_rst", vb, hb, 18'h2A5C3);

      // Single-channel instance, zero gap, 24-bit frame
      @(posedge clk); #1; strr2 = 1'b1;
      @(posedge clk); #1; strr2 = 1'b0;
      for (int i = 0; i < 24; i++) tick(1'b1, (i < 6) ? 1'b0 : 1'b1);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("n1_valid_count", v2_n, 32'd1);
      chk("n1_data", {14'd0, v2_data}, 32'h3FFFF);
      chk("n1_hab_count", h2_n, 32'd1);
      chk("n1_hab_after_valid", h2_cyc, v2_cyc + 1);
      chk("n1_cnt_peak", cnt2_max, 32'd24);
      chk("n1_eor_end", {31'd0, eor2}, 32'd1);
      chk("n1_ch", {31'd0, ch2}, 32'd0);

`ifdef SPIR_CONT_EN
      // Continuous scanning: two back-to-back scans from one start request
      begin
         int e0, e1;
         vb = vdata.size(); hb = hab_n;
         cont = 1'b1;
         pulse_strr();
         @(negedge clk);
         e0 = eor_hi;
         for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 4; c++) begin
               if (s == 1 && c == 3) cont = 1'b0;
               frame_part(1'b0, 18'h2A5C3, 0, 32);
               if (c < 3) gap(1'b0);
            end
            if (s == 0) repeat (4) @(posedge clk);
         end
         @(negedge clk);
         e1 = eor_hi;
         repeat (6) @(posedge clk);
         @(negedge clk);
         chk("cont_eor_held_low", e1 - e0, 32'd0);
         chk("cont_valid_count", vdata.size() - vb, 32'd8);
         chk("cont_hab_count", hab_n - hb, 32'd2);
         if (vdata.size() >= vb + 8) begin
            chk("cont_restart_ch", vch[vb+4], 32'd0);
            chk("cont_last_ch", vch[vb+7], 32'd3);
            chk("cont_data", {14'd0, vdata[vb+7]}, 32'h2A5C3);
         end
         chk("cont_eor_end", {31'd0, eor}, 32'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
